// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// the legality check used when a request is accepted.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
    function automatic logic is_legal_funct3(input logic we, input logic [2:0] f3);
        logic legal;
        legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return legal;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data path: extends sub-word load data and merges sub-word
// store data into the word read back from memory.
module lsu_data_align
    import mem_access_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] word,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] load_data,
    output logic [WORD_SIZE-1:0] merge_data
);

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{(WORD_SIZE-8){word[7]}}, word[7:0]};
            F3_BU:   load_data = {{(WORD_SIZE-8){1'b0}}, word[7:0]};
            F3_H:    load_data = {{(WORD_SIZE-16){word[15]}}, word[15:0]};
            F3_HU:   load_data = {{(WORD_SIZE-16){1'b0}}, word[15:0]};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merge_data = wdata;
        case (funct3)
            F3_B:    merge_data = {word[WORD_SIZE-1:8], wdata[7:0]};
            F3_H:    merge_data = {word[WORD_SIZE-1:16], wdata[15:0]};
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a word-write, byte-addressed
// memory port; sub-word stores are done as read-modify-write.
//
// state  | meaning
// IDLE   | ready for a request; acceptance registers it
// LOAD   | capture extended read data
// RMW_RD | read word and merge SB/SH data into it
// STORE  | single-cycle memory write strobe
// RESP   | one-cycle response pulse
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 mem_write_en,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_write_data,
    input  logic [WORD_SIZE-1:0] mem_data
);

    state_t               state_q, state_d;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 err_q;
    logic [WORD_SIZE-1:0] merge_q;
    logic [WORD_SIZE-1:0] load_data;
    logic [WORD_SIZE-1:0] merge_data;
    logic                 req_err;

    assign req_err = !is_legal_funct3(req_we, req_funct3) ||
                     (req_addr >= WORD_SIZE'(MEM_SIZE));

    lsu_data_align #(.WORD_SIZE(WORD_SIZE)) u_align (
        .funct3     (f3_q),
        .word       (mem_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                 state_d = RESP;
                    else if (!req_we)            state_d = LOAD;
                    else if (req_funct3 == F3_W) state_d = STORE;
                    else                         state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = STORE;
            STORE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == IDLE);
        resp_valid     = (state_q == RESP);
        mem_write_en   = (state_q == STORE) && we_q;
        mem_write_data = (f3_q == F3_W) ? wdata_q : merge_q;
        mem_addr       = addr_q;
        resp_rdata     = rdata_q;
        resp_err       = err_q;
    end

    // rdata_q/err_q only change on the way into RESP so they hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= load_data;
                    err_q   <= 1'b0;
                end
                RMW_RD: merge_q <= merge_data;
                STORE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
